conv2d_stream: RTL and testbench
================================

# conv2d_stream

Streaming, parametrised 2-D convolution engine for the LeNet accelerator datapath. It generalises the fixed whole-array convolution stages to any image size, kernel size, data width and number of output kernels. Weights are loaded serially once. Pixels then arrive one per beat in raster order, are windowed through internal line buffers, and every valid K×K window position produces NUM_K dot products in parallel over a valid/ready handshake. It sits between the image source, or a previous layer, and the next pooling or convolution stage.

## Interface
- BITWIDTH, 32, signed two's-complement width of pixels, weights and results
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, square kernel size (2 ≤ K ≤ min(IMG_W, IMG_H))
- NUM_K, 2, number of kernels (output channels) computed in parallel
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_valid  in  1  weight beat valid
- w_ready  out  1  engine accepts weights (state LOAD_W)
- w_data  in  BITWIDTH  weight; order is kernel n, then row i, then column j, all ascending
- w_load  in  1  request weight reload (takes effect only between frames)
- in_valid  in  1  pixel beat valid
- in_ready  out  1  engine accepts pixel
- in_data  in  BITWIDTH  pixel, raster order (row 0 col 0 first)
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts result
- out_data  out  NUM_K*BITWIDTH  kernel n result at [n*BITWIDTH +: BITWIDTH]
- out_last  out  1  marks the final window of a frame
- frame_done  out  1  one-cycle pulse after the last result of a frame is accepted

## Operation
- Two states:
  - LOAD_W: w_ready=1, in_ready=0. A transfer (w_valid&w_ready) writes the next weight slot. After NUM_K*K*K beats, go to RUN.
  - RUN: w_ready=0. Frame pixels are accepted here.
- w_load in RUN with no frame in progress (pixel counter 0 and out_valid=0) returns to LOAD_W on the next cycle. It is ignored mid-frame. Weights are retained across frames until reloaded.
- Pixel transfer = in_valid&in_ready. On each transfer:
  - Shift the pixel into the K×K window register and K-1 line buffers of depth IMG_W.
  - Advance col (0..IMG_W-1) and row (0..IMG_H-1) counters.
  - col wraps to 0 and row increments at IMG_W-1.
  - After pixel (IMG_H-1, IMG_W-1), both counters clear to 0 and the next frame begins immediately; no idle cycle is required.
- A window is valid when the accepted pixel has row ≥ K-1 and col ≥ K-1. That window's top-left corner is (row-K+1, col-K+1). Windows never straddle a row wrap.
- Results per frame: (IMG_W-K+1)*(IMG_H-K+1); 576 for the default parameters.
- Arithmetic:
  - result[n] = Σ w[n][i][j]*pix[r+i][c+j], computed at full precision.
  - Output is the low BITWIDTH bits (two's-complement wrap). There is no saturation and no bias.
- out_last=1 with the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
- Reset (at any time, including mid-frame):
  - Enter LOAD_W; clear the weight count to 0 and all weights to 0.
  - Clear line buffers, window and counters.
  - Reset values: out_valid=0, out_data=0, out_last=0, frame_done=0, in_ready=0, w_ready=1.
  - Any beat presented while rst=1 is ignored.

## Timing
- in_ready = (state==RUN) && (!out_valid || out_ready), combinational. No skid buffer.
- Latency: a window-completing pixel accepted at edge t gives out_valid=1 with out_data/out_last valid from edge t, i.e. one register stage.
- Output register:
  - Loads on a window-completing transfer.
  - Clears out_valid on out_valid&out_ready when no new window loads in the same cycle.
  - When accept and load coincide, the new result replaces the old with out_valid held at 1.
- While out_valid=1 and out_ready=0: out_data and out_last are stable and no pixel is accepted.
- frame_done is asserted the cycle after the out_last result transfers.
- Throughput: one pixel per cycle with out_ready held at 1.
- The first result of a frame appears after (K-1)*IMG_W+K accepted pixels.

## Test plan
- Identity kernel: kernel0 w[0][0]=1, all other weights 0; image all 0 except pixel (0,0)=3. Required: first result kernel0=3, kernel1=0; all 575 remaining results 0; out_last only on result 576; frame_done follows.
- All-ones weights in both kernels, all-ones 28×28 image, out_ready=1. Required: 576 results, each field=25; one result per cycle once the window fills; first out_valid after the 117th pixel.
- Backpressure: drop out_ready for 10 cycles mid-frame. Required: in_ready=0, out_data stable, no lost or duplicated result; the full 576-result sequence is unchanged versus the unstalled run.
- Wrap arithmetic: weight w[0][0][0]=0x7FFFFFFF, pixel (0,0)=2, all else 0. Required: kernel0 first result 0xFFFFFFFE.
- Reset mid-frame: assert rst after 300 pixels. Required: next cycle out_valid=0, in_ready=0, w_ready=1. Reloading weights and a full frame gives the same results as a clean run.
- Reload between frames:
  - w_load after frame_done; load weights = 2, image all ones. Required: every result 50.
  - w_load asserted mid-frame. Required: ignored, frame completes with 576 results.

Source files
------------

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK convolution over a raster pixel stream,
// producing NUM_K kernel results per valid window position.
module conv2d_stream #(
    parameter int BITWIDTH = 32,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 5,
    parameter int NUM_K    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [BITWIDTH-1:0]       w_data,
    input  logic                      w_load,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITWIDTH-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_K*BITWIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      frame_done
);
    localparam int NW  = NUM_K * K * K;
    localparam int HD  = (K - 1) * IMG_W + K - 1;
    localparam int WCW = $clog2(NW);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);

    typedef enum logic {LOAD_W, RUN} state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [BITWIDTH-1:0]         wts   [NW];
    logic [BITWIDTH-1:0]         hist  [HD];
    logic [BITWIDTH-1:0]         taps  [HD+1];
    logic [BITWIDTH-1:0]         acc   [NUM_K];
    logic [NUM_K*BITWIDTH-1:0]   acc_flat;
    logic [WCW-1:0]              w_cnt;
    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    logic                        w_xfer;
    logic                        in_xfer;
    logic                        out_xfer;
    logic                        frame_end;
    logic                        win_hit;
    logic                        idle;

    assign w_xfer    = w_valid && w_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign frame_end = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign win_hit   = in_xfer && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
    // A reload must not swallow a pixel that would open a new frame
    assign idle      = (row == '0) && (col == '0) && !out_valid && !in_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD_W;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        w_ready  = 1'b0;
        in_ready = 1'b0;
        unique case (state)
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && w_cnt == WCW'(NW - 1)) state_nx = RUN;
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (w_load && idle) state_nx = LOAD_W;
            end
            default: state_nx = LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_cnt <= '0;
            for (int i = 0; i < NW; i++) wts[i] <= '0;
        end else if (w_xfer) begin
            wts[w_cnt] <= w_data;
            w_cnt      <= (w_cnt == WCW'(NW - 1)) ? '0 : w_cnt + 1'b1;
        end
    end

    // One long shift register: K-1 line buffers plus the window columns
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            for (int i = 0; i < HD; i++) hist[i] <= '0;
        end else if (in_xfer) begin
            hist[0] <= in_data;
            for (int i = 1; i < HD; i++) hist[i] <= hist[i-1];
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= frame_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        taps[0] = in_data;
        for (int i = 1; i <= HD; i++) taps[i] = hist[i-1];
    end

    // Low bits of a product sum do not depend on operand signedness
    always_comb begin
        acc_flat = '0;
        for (int n = 0; n < NUM_K; n++) begin
            acc[n] = '0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    acc[n] = acc[n] + wts[n*K*K + i*K + j]
                           * taps[(K-1-i)*IMG_W + (K-1-j)];
                end
            end
            acc_flat[n*BITWIDTH +: BITWIDTH] = acc[n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_xfer && out_last;
            if (win_hit) begin
                out_valid <= 1'b1;
                out_data  <= acc_flat;
                out_last  <= frame_end;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: frames driven through conv2d_stream and compared
// against a direct-sum convolution model.
module tb_conv2d_stream;
    localparam int BW   = 32;
    localparam int IW   = 28;
    localparam int IH   = 28;
    localparam int KK   = 5;
    localparam int NK   = 2;
    localparam int NPIX = IW * IH;
    localparam int NRES = (IW - KK + 1) * (IH - KK + 1);
    localparam int NW   = NK * KK * KK;
    localparam int FILL = (KK - 1) * IW + KK;

    logic              clk = 1'b0;
    logic              rst;
    logic              w_valid;
    logic              w_ready;
    logic [BW-1:0]     w_data;
    logic              w_load;
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [NK*BW-1:0]  out_data;
    logic              out_last;
    logic              frame_done;

    always #5 clk = ~clk;

    conv2d_stream #(
        .BITWIDTH(BW), .IMG_W(IW), .IMG_H(IH), .K(KK), .NUM_K(NK)
    ) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_load(w_load),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .frame_done(frame_done)
    );

    int errors = 0;
    int checks = 0;

    logic [BW-1:0]    wts [NK][KK][KK];
    logic [BW-1:0]    img [IH][IW];
    logic [NK*BW-1:0] exp_q[$];
    logic [NK*BW-1:0] got_q[$];
    logic [NK*BW-1:0] ref_q[$];
    int last_pos, last_cnt, fd_bad, first_ov;
    int stall_bad, bp_bad, bp_seen, timeout;

    task automatic fill(input bit wrnd, input logic [BW-1:0] wv,
                        input bit irnd, input logic [BW-1:0] iv);
        for (int n = 0; n < NK; n++)
            for (int i = 0; i < KK; i++)
                for (int j = 0; j < KK; j++)
                    wts[n][i][j] = wrnd ? $urandom : wv;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = irnd ? $urandom : iv;
    endtask

    // Reference: direct sum at 64-bit precision, low BW bits kept
    task automatic build_exp();
        exp_q.delete();
        for (int r = 0; r <= IH - KK; r++) begin
            for (int c = 0; c <= IW - KK; c++) begin
                logic [NK*BW-1:0] v;
                v = '0;
                for (int n = 0; n < NK; n++) begin
                    longint s;
                    s = 0;
                    for (int i = 0; i < KK; i++)
                        for (int j = 0; j < KK; j++)
                            s += longint'(signed'(wts[n][i][j]))
                               * longint'(signed'(img[r+i][c+j]));
                    v[n*BW +: BW] = s[BW-1:0];
                end
                exp_q.push_back(v);
            end
        end
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic load_weights(input int gap);
        int k = 0;
        int cyc = 0;
        while (k < NW && cyc < 2000) begin
            @(negedge clk);
            w_valid = ($urandom_range(99) >= gap);
            w_data  = wts[k / (KK*KK)][(k / KK) % KK][k % KK];
            #1;
            if (w_valid && w_ready) k++;
            cyc++;
        end
        @(negedge clk);
        w_valid = 1'b0;
        checks++;
        if (k != NW) begin
            errors++;
            $display("FAIL weight_load: loaded %0d required %0d", k, NW);
        end
    endtask

    task automatic reload();
        @(negedge clk);
        w_load = 1'b1;
        @(negedge clk);
        w_load = 1'b0;
    endtask

    task automatic run_frame(input int gap, input int stall, input int max_pix,
                             input int bp_at, input int wl_at);
        int pix = 0;
        int cyc = 0;
        int bp_left = 0;
        bit fin = 0;
        bit bp_done = 0;
        bit have_hold = 0;
        logic [NK*BW-1:0] hold = '0;
        got_q.delete();
        last_pos = -1; last_cnt = 0; fd_bad = 0; first_ov = -1;
        stall_bad = 0; bp_bad = 0; bp_seen = 0; timeout = 0;
        forever begin
            @(negedge clk);
            if (fin) begin
                if (frame_done !== 1'b1) fd_bad++;
                break;
            end
            if (frame_done !== 1'b0) fd_bad++;
            if (max_pix < NPIX && pix >= max_pix) break;
            if (cyc >= 8000) begin
                timeout = 1;
                break;
            end
            if (bp_at >= 0 && !bp_done && got_q.size() >= bp_at) begin
                bp_left = 10;
                bp_done = 1;
            end
            in_valid  = (pix < max_pix) && ($urandom_range(99) >= gap);
            in_data   = (pix < NPIX) ? img[pix / IW][pix % IW] : '0;
            out_ready = (bp_left > 0) ? 1'b0 : ($urandom_range(99) >= stall);
            w_load    = (pix == wl_at);
            #1;
            if (out_valid && first_ov < 0) first_ov = pix;
            if (bp_left > 0) begin
                bp_left--;
                if (out_valid) begin
                    bp_seen++;
                    if (in_ready !== 1'b0) bp_bad++;
                    if (have_hold && out_data !== hold) bp_bad++;
                    hold = out_data;
                    have_hold = 1;
                end
            end
            if (stall == 0 && in_valid && !in_ready) stall_bad++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (out_last) begin
                    last_cnt++;
                    last_pos = got_q.size() - 1;
                    fin = 1;
                end
            end
            if (in_valid && in_ready) pix++;
            cyc++;
        end
        in_valid = 1'b0;
        w_load = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_valid = 1'b1; in_valid = 1'b1; w_load = 1'b1;
        out_ready = 1'b1; w_data = '1; in_data = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0; w_valid = 1'b0; in_valid = 1'b0; w_load = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h required 0", out_data); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        checks++;
        if (w_ready !== 1'b1) begin errors++; $display("FAIL rst_w_ready: got %b required 1", w_ready); end
    endtask

    task automatic test_identity();
        logic [NK*BW-1:0] want;
        fill(0, '0, 0, '0);
        wts[0][0][0] = 1;
        img[0][0] = 3;
        build_exp();
        load_weights(20);
        run_frame(0, 0, NPIX, -1, -1);
        want = {32'd0, 32'd3};
        checks++;
        if (timeout != 0 || got_q.size() != NRES) begin errors++; $display("FAIL ident_count: got %0d required %0d", got_q.size(), NRES); end
        checks++;
        if (got_q[0] !== want) begin errors++; $display("FAIL ident_first: got %h required %h", got_q[0], want); end
        checks++;
        if (first_diff() != -1) begin errors++; $display("FAIL ident_seq: first bad index %0d required -1", first_diff()); end
        checks++;
        if (last_cnt != 1 || last_pos != NRES - 1) begin errors++; $display("FAIL ident_last: got pos %0d count %0d required pos %0d count 1", last_pos, last_cnt, NRES - 1); end
        checks++;
        if (fd_bad != 0) begin errors++; $display("FAIL ident_frame_done: bad cycles %0d required 0", fd_bad); end
    endtask

    task automatic test_ones();
        logic [NK*BW-1:0] want;
        fill(0, 1, 0, 1);
        build_exp();
        reload();
        load_weights(0);
        run_frame(0, 0, NPIX, -1, -1);
        want = {NK{32'd25}};
        checks++;
        if (first_diff() != -1) begin errors++; $display("FAIL ones_seq: first bad index %0d required -1", first_diff()); end
        checks++;
        if (got_q[NRES/2] !== want) begin errors++; $display("FAIL ones_value: got %h required %h", got_q[NRES/2], want); end
        checks++;
        if (first_ov != FILL) begin errors++; $display("FAIL ones_fill: first valid after %0d pixels required %0d", first_ov, FILL); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL ones_rate: stalled cycles %0d required 0", stall_bad); end
        checks++;
        if (fd_bad != 0 || last_pos != NRES - 1) begin errors++; $display("FAIL ones_end: fd_bad %0d last %0d required 0 and %0d", fd_bad, last_pos, NRES - 1); end
    endtask

    task automatic test_backpressure();
        fill(1, '0, 1, '0);
        build_exp();
        reload();
        load_weights(30);
        run_frame(0, 0, NPIX, -1, -1);
        ref_q = got_q;
        run_frame(0, 0, NPIX, 200, -1);
        checks++;
        if (bp_seen != 10 || bp_bad != 0) begin errors++; $display("FAIL bp_hold: stalled %0d bad %0d required 10 and 0", bp_seen, bp_bad); end
        checks++;
        if (got_q != ref_q) begin errors++; $display("FAIL bp_vs_unstalled: got %0d results required %0d identical", got_q.size(), ref_q.size()); end
        checks++;
        if (first_diff() != -1) begin errors++; $display("FAIL bp_seq: first bad index %0d required -1", first_diff()); end
    endtask

    task automatic test_wrap();
        fill(0, '0, 0, '0);
        wts[0][0][0] = 32'h7FFF_FFFF;
        img[0][0] = 2;
        build_exp();
        reload();
        load_weights(10);
        run_frame(10, 10, NPIX, -1, -1);
        checks++;
        if (got_q[0][BW-1:0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_first: got %h required fffffffe", got_q[0][BW-1:0]); end
        checks++;
        if (first_diff() != -1) begin errors++; $display("FAIL wrap_seq: first bad index %0d required -1", first_diff()); end
    endtask

    task automatic test_reset_mid();
        fill(1, '0, 1, '0);
        build_exp();
        reload();
        load_weights(0);
        run_frame(20, 20, 300, -1, -1);
        rst = 1'b1; in_valid = 1'b1; w_valid = 1'b1; w_load = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; w_valid = 1'b0; w_load = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || w_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: out_valid %b in_ready %b w_ready %b required 0 0 1", out_valid, in_ready, w_ready);
        end
        load_weights(20);
        run_frame(20, 20, NPIX, -1, -1);
        checks++;
        if (timeout != 0 || first_diff() != -1) begin errors++; $display("FAIL rstmid_seq: first bad index %0d required -1", first_diff()); end
        checks++;
        if (last_pos != NRES - 1 || fd_bad != 0) begin errors++; $display("FAIL rstmid_end: last %0d fd_bad %0d required %0d and 0", last_pos, fd_bad, NRES - 1); end
    endtask

    task automatic test_reload();
        logic [NK*BW-1:0] want;
        fill(0, 2, 0, 1);
        build_exp();
        reload();
        #1;
        checks++;
        if (w_ready !== 1'b1) begin errors++; $display("FAIL reload_w_ready: got %b required 1", w_ready); end
        load_weights(0);
        run_frame(0, 0, NPIX, -1, -1);
        want = {NK{32'd50}};
        checks++;
        if (got_q[NRES-1] !== want) begin errors++; $display("FAIL reload_value: got %h required %h", got_q[NRES-1], want); end
        checks++;
        if (first_diff() != -1) begin errors++; $display("FAIL reload_seq: first bad index %0d required -1", first_diff()); end
    endtask

    task automatic test_wload_mid();
        fill(0, 2, 1, '0);
        build_exp();
        run_frame(10, 10, NPIX, -1, 150);
        checks++;
        if (got_q.size() != NRES || first_diff() != -1) begin errors++; $display("FAIL wload_mid_seq: got %0d results first bad %0d required %0d and -1", got_q.size(), first_diff(), NRES); end
        #1;
        checks++;
        if (w_ready !== 1'b0) begin errors++; $display("FAIL wload_mid_state: w_ready %b required 0", w_ready); end
    endtask

    task automatic test_random();
        fill(1, '0, 1, '0);
        build_exp();
        reload();
        load_weights(40);
        for (int f = 0; f < 2; f++) begin
            run_frame(30, 30, NPIX, -1, -1);
            checks++;
            if (timeout != 0 || first_diff() != -1) begin errors++; $display("FAIL random_frame%0d: first bad index %0d required -1", f, first_diff()); end
            checks++;
            if (last_cnt != 1 || fd_bad != 0) begin errors++; $display("FAIL random_end%0d: last count %0d fd_bad %0d required 1 and 0", f, last_cnt, fd_bad); end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_identity();
        test_ones();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_reload();
        test_wload_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
